// File: rtl/nic_cpu_responder_if.sv
// nic_cpu_responder_if: CPU register port plus router local-port signals of a NIC.
//   master : CPU/router side (drives nicAddr/nicEn/nicWrEn/nicDataIn, net_si/net_di,
//            net_ro, net_polarity; observes nicDataOut, net_ri, net_so, net_do)
//   slave  : NIC side (the mirror image)
// Data vectors are big-endian: bit 0 is the MSB.
interface nic_cpu_responder_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] nicAddr;
  logic                  nicEn;
  logic                  nicWrEn;
  logic [0:DATA_WIDTH-1] nicDataIn;
  logic [0:DATA_WIDTH-1] nicDataOut;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport master (
    output nicAddr, nicEn, nicWrEn, nicDataIn, net_si, net_di, net_ro, net_polarity,
    input  nicDataOut, net_ri, net_so, net_do
  );

  modport slave (
    input  nicAddr, nicEn, nicWrEn, nicDataIn, net_si, net_di, net_ro, net_polarity,
    output nicDataOut, net_ri, net_so, net_do
  );
endinterface

// File: rtl/nic_cpu_responder.sv
// nic_cpu_responder: CPU-side register responder and router-side endpoint of a ring node.
// Holds one packet per direction, each with a full flag.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   nic    : nic_cpu_responder_if.slave (CPU register port + router send/ready channels)
// Register map: 0 input buffer (RO), 1 input status (RO), 2 output buffer (WO),
//   3 output status (RO). Status word: bit 63 (LSB) = full, bit 62 = overflow.
// Option: define NIC_OVERFLOW_FLAG_EN for a sticky overflow flag set by writes dropped while
//   the output buffer is full; reported in output status bit 62, cleared by an addr-3 read.
module nic_cpu_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input logic                clk,
  input logic                reset,
  nic_cpu_responder_if.slave nic
);

  typedef logic [0:DATA_WIDTH-1] wordT;

  localparam logic [ADDR_WIDTH-1:0] addrInBuf     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] addrInStatus  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] addrOutBuf    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] addrOutStatus = ADDR_WIDTH'(3);

  wordT inBufQ, inBufD, outBufQ, outBufD;
  logic inFullQ, inFullD, outFullQ, outFullD;
  logic rdEn, wrEn, inCapture, inRelease, outWrite, outSend, ovfQ;
  wordT inStatus, outStatus;

  assign rdEn      = nic.nicEn & ~nic.nicWrEn;
  assign wrEn      = nic.nicEn & nic.nicWrEn;
  assign inCapture = nic.net_si & ~inFullQ;
  assign inRelease = rdEn & (nic.nicAddr == addrInBuf) & inFullQ;
  // Writes are accepted only into an empty buffer; this also drops a write landing in the
  // same cycle the router takes the packet.
  assign outWrite  = wrEn & (nic.nicAddr == addrOutBuf) & ~outFullQ;

  assign nic.net_ri = ~inFullQ;
  // Bit 0 of the packet selects the virtual channel; inject only on the matching polarity.
  assign nic.net_so = outFullQ & (outBufQ[0] == nic.net_polarity);
  assign nic.net_do = outBufQ;
  assign outSend    = nic.net_so & nic.net_ro;

`ifdef NIC_OVERFLOW_FLAG_EN
  logic ovfD, outDrop;
  assign outDrop = wrEn & (nic.nicAddr == addrOutBuf) & outFullQ;

  always_comb begin
    ovfD = ovfQ;
    if (outDrop) begin
      ovfD = 1'b1;
    end else if (rdEn && (nic.nicAddr == addrOutStatus)) begin
      ovfD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfQ <= 1'b0;
    end else begin
      ovfQ <= ovfD;
    end
  end
`else
  assign ovfQ = 1'b0;
`endif

  always_comb begin
    inStatus                = '0;
    inStatus[DATA_WIDTH-1]  = inFullQ;
    outStatus               = '0;
    outStatus[DATA_WIDTH-1] = outFullQ;
    outStatus[DATA_WIDTH-2] = ovfQ;
  end

  always_comb begin
    nic.nicDataOut = '0;
    if (rdEn) begin
      case (nic.nicAddr)
        addrInBuf:     nic.nicDataOut = inBufQ;
        addrInStatus:  nic.nicDataOut = inStatus;
        addrOutStatus: nic.nicDataOut = outStatus;
        default:       nic.nicDataOut = '0;
      endcase
    end
  end

  // Capture needs an empty buffer and release a full one, so they never coincide;
  // likewise for write and send on the output side.
  always_comb begin
    inBufD   = inBufQ;
    inFullD  = inFullQ;
    outBufD  = outBufQ;
    outFullD = outFullQ;
    if (inCapture) begin
      inBufD  = nic.net_di;
      inFullD = 1'b1;
    end else if (inRelease) begin
      inFullD = 1'b0;
    end
    if (outWrite) begin
      outBufD  = nic.nicDataIn;
      outFullD = 1'b1;
    end else if (outSend) begin
      outFullD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inBufQ   <= '0;
      inFullQ  <= 1'b0;
      outBufQ  <= '0;
      outFullQ <= 1'b0;
    end else begin
      inBufQ   <= inBufD;
      inFullQ  <= inFullD;
      outBufQ  <= outBufD;
      outFullQ <= outFullD;
    end
  end

endmodule

// File: tb/tb_nic_cpu_responder.sv
// tb_nic_cpu_responder: directed bench for nic_cpu_responder with a queue-based reference
// model compared against every DUT output each cycle, plus literal spot checks.
module tb_nic_cpu_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  nic_cpu_responder_if intf ();

  nic_cpu_responder dut (
    .clk   (clk),
    .reset (reset),
    .nic   (intf)
  );

  always #5 clk = ~clk;

`ifdef NIC_OVERFLOW_FLAG_EN
  localparam logic [63:0] DropStatus = 64'h3;
`else
  localparam logic [63:0] DropStatus = 64'h1;
`endif

  int nCmp = 0;
  int nBad = 0;

  // Reference model: a packet sits in a one-deep queue per direction; "last" holds the
  // most recent packet so stale reads and the held net_do value can be predicted.
  logic [63:0] mdlInQ[$];
  logic [63:0] mdlOutQ[$];
  logic [63:0] mdlInLast;
  logic [63:0] mdlOutLast;
  bit          mdlOvf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] expRead();
    if (!intf.nicEn || intf.nicWrEn) return 64'h0;
    case (intf.nicAddr)
      2'd0:    return mdlInLast;
      2'd1:    return 64'(mdlInQ.size());
      2'd2:    return 64'h0;
      default: return (mdlOvf ? 64'h2 : 64'h0) + 64'(mdlOutQ.size());
    endcase
  endfunction

  function automatic bit expSo();
    return (mdlOutQ.size() != 0) && (mdlOutLast[63] == intf.net_polarity);
  endfunction

  task automatic compareAll();
    check("net_ri", 64'(intf.net_ri), 64'(mdlInQ.size() == 0));
    check("net_so", 64'(intf.net_so), 64'(expSo()));
    check("net_do", intf.net_do, mdlOutLast);
    check("nicDataOut", intf.nicDataOut, expRead());
  endtask

  task automatic modelStep();
    bit rd, wrA2, cap, pop, snd, wok;
    rd   = intf.nicEn && !intf.nicWrEn;
    wrA2 = intf.nicEn && intf.nicWrEn && (intf.nicAddr == 2'd2);
    cap  = intf.net_si && (mdlInQ.size() == 0);
    pop  = rd && (intf.nicAddr == 2'd0) && (mdlInQ.size() != 0);
    snd  = expSo() && intf.net_ro;
    wok  = wrA2 && (mdlOutQ.size() == 0);
`ifdef NIC_OVERFLOW_FLAG_EN
    if (wrA2 && (mdlOutQ.size() != 0)) mdlOvf = 1'b1;
    else if (rd && (intf.nicAddr == 2'd3)) mdlOvf = 1'b0;
`endif
    if (pop) void'(mdlInQ.pop_front());
    if (cap) begin
      mdlInQ.push_back(intf.net_di);
      mdlInLast = intf.net_di;
    end
    if (snd) void'(mdlOutQ.pop_front());
    if (wok) begin
      mdlOutQ.push_back(intf.nicDataIn);
      mdlOutLast = intf.nicDataIn;
    end
  endtask

  task automatic modelReset();
    mdlInQ.delete();
    mdlOutQ.delete();
    mdlInLast  = 64'h0;
    mdlOutLast = 64'h0;
    mdlOvf     = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge, then
  // toggle the router polarity just after it.
  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    if (reset) modelStep();
    #1;
    intf.net_polarity = ~intf.net_polarity;
  endtask

  task automatic rd(input logic [1:0] a);
    intf.nicEn   = 1'b1;
    intf.nicWrEn = 1'b0;
    intf.nicAddr = a;
  endtask

  task automatic wrt(input logic [1:0] a, input logic [63:0] d);
    intf.nicEn     = 1'b1;
    intf.nicWrEn   = 1'b1;
    intf.nicAddr   = a;
    intf.nicDataIn = d;
  endtask

  task automatic idle();
    intf.nicEn   = 1'b0;
    intf.nicWrEn = 1'b0;
    intf.nicAddr = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sent;
    modelReset();
    idle();
    intf.nicDataIn    = '0;
    intf.net_si       = 1'b0;
    intf.net_di       = '0;
    intf.net_ro       = 1'b0;
    intf.net_polarity = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_ri", 64'(intf.net_ri), 64'h1);
    check("rst_so", 64'(intf.net_so), 64'h0);

    // Receive
    intf.net_si = 1'b1;
    intf.net_di = 64'hA5A5_0000_0000_0001;
    tick();
    intf.net_si = 1'b0;
    rd(2'd1);
    #1;
    check("rx_status_full", intf.nicDataOut, 64'h1);
    check("rx_ri_low", 64'(intf.net_ri), 64'h0);
    tick();
    rd(2'd0);
    #1;
    check("rx_data", intf.nicDataOut, 64'hA5A5_0000_0000_0001);
    tick();
    idle();
    #1;
    check("rx_ri_back", 64'(intf.net_ri), 64'h1);
    rd(2'd1);
    #1;
    check("rx_status_empty", intf.nicDataOut, 64'h0);
    tick();
    idle();

    // Backpressure
    intf.net_si = 1'b1;
    intf.net_di = 64'h1111_2222_3333_4444;
    tick();
    intf.net_di = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ri", 64'(intf.net_ri), 64'h0);
      tick();
    end
    rd(2'd0);
    #1;
    check("bp_keep", intf.nicDataOut, 64'h1111_2222_3333_4444);
    tick();
    idle();
    #1;
    check("bp_ri_after_read", 64'(intf.net_ri), 64'h1);
    tick();
    intf.net_si = 1'b0;
    rd(2'd0);
    #1;
    check("bp_refill", intf.nicDataOut, 64'h5555_6666_7777_8888);
    tick();
    idle();

    // Inject
    wrt(2'd2, 64'h8000_0000_0000_00FF);
    #1;
    check("inj_so_write_cycle", 64'(intf.net_so), 64'h0);
    tick();
    idle();
    intf.net_ro = 1'b1;
    sent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("inj_so", 64'(intf.net_so), sent ? 64'h0 : 64'(intf.net_polarity));
      check("inj_do", intf.net_do, 64'h8000_0000_0000_00FF);
      if (intf.net_polarity) sent = 1'b1;
      tick();
    end
    rd(2'd3);
    #1;
    check("inj_status", intf.nicDataOut, 64'h0);
    tick();
    idle();
    intf.net_ro = 1'b0;

    // Drop
    wrt(2'd2, 64'h0000_0000_0000_0055);
    tick();
    wrt(2'd2, 64'h1234);
    tick();
    wrt(2'd0, 64'hDEAD);
    tick();
    idle();
    #1;
    check("drop_keep", intf.net_do, 64'h0000_0000_0000_0055);
    rd(2'd3);
    #1;
    check("drop_status1", intf.nicDataOut, DropStatus);
    tick();
    #1;
    check("drop_status2", intf.nicDataOut, 64'h1);
    tick();
    idle();
    intf.net_ro = 1'b1;
    tick();
    tick();
    intf.net_ro = 1'b0;
    rd(2'd3);
    #1;
    check("drop_drained", intf.nicDataOut, 64'h0);
    tick();
    idle();

    // Concurrency: input handshake, output handshake and stale addr-0 read together
    wrt(2'd2, 64'h0000_0000_0000_0066);
    tick();
    idle();
    if (intf.net_polarity) tick();
    intf.net_ro = 1'b1;
    intf.net_si = 1'b1;
    intf.net_di = 64'hCAFE_0000_0000_0006;
    rd(2'd0);
    #1;
    check("cc_so", 64'(intf.net_so), 64'h1);
    check("cc_ri", 64'(intf.net_ri), 64'h1);
    check("cc_stale", intf.nicDataOut, 64'h5555_6666_7777_8888);
    tick();
    intf.net_si = 1'b0;
    intf.net_ro = 1'b0;
    rd(2'd3);
    #1;
    check("cc_out_empty", intf.nicDataOut, 64'h0);
    rd(2'd0);
    #1;
    check("cc_in_data", intf.nicDataOut, 64'hCAFE_0000_0000_0006);
    check("cc_ri_low", 64'(intf.net_ri), 64'h0);
    tick();
    idle();

    // Mid-cycle reset with both buffers loaded
    intf.net_si = 1'b1;
    intf.net_di = 64'h0BAD_0000_0000_0007;
    wrt(2'd2, 64'h8000_0000_0000_0001);
    tick();
    intf.net_si = 1'b0;
    idle();
    #1;
    reset = 1'b0;
    modelReset();
    #1;
    check("mrst_ri", 64'(intf.net_ri), 64'h1);
    check("mrst_so", 64'(intf.net_so), 64'h0);
    check("mrst_do", intf.net_do, 64'h0);
    rd(2'd1);
    #1;
    check("mrst_status1", intf.nicDataOut, 64'h0);
    rd(2'd3);
    #1;
    check("mrst_status3", intf.nicDataOut, 64'h0);
    tick();
    reset = 1'b1;
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
